// File: rtl/adc_spi_sampler.sv
// SPI master for an LTC2308-style 12-bit ADC: periodic CONVST, conversion wait, 12-bit frame, holding register.
// Build option ADC_AVG_EN: sample becomes the truncated mean of the last four raw results.
module adc_spi_sampler #(
    parameter int CLK_DIV       = 2,
    parameter int CONV_CYCLES   = 80,
    parameter int SAMPLE_PERIOD = 200,
    parameter int CHANNEL       = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        adc_sdo,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    output logic [11:0] sample,
    output logic        sample_valid
);
    localparam int TMAX = (CONV_CYCLES > 2 * CLK_DIV) ? CONV_CYCLES : 2 * CLK_DIV;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    localparam logic [TW-1:0] CONVST_LAST = TW'(1);
    localparam logic [TW-1:0] CONV_LAST   = TW'(CONV_CYCLES - 1);
    localparam logic [TW-1:0] BIT_LAST    = TW'(2 * CLK_DIV - 1);
    localparam logic [TW-1:0] SCK_RISE    = TW'(CLK_DIV);
    localparam logic [PW-1:0] PER_LAST    = PW'(SAMPLE_PERIOD - 1);
    localparam logic [2:0]    CH          = 3'(CHANNEL);
    // {S/D, O/S, S1, S0, UNI, SLP} followed by six don't-care zeros
    localparam logic [11:0]   CFG         = {1'b1, CH[0], CH[2], CH[1], 1'b1, 1'b0, 6'b0};

    typedef enum logic [2:0] {IDLE, CONVST, WAIT, SHIFT, DONE} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tick, tick_nxt;
    logic [3:0]    bit_cnt, bit_nxt;
    logic [PW-1:0] per_cnt;
    logic          pending;
    logic          req;
    logic          start;
    logic [11:0]   shreg;

    // A period boundary seen mid-frame is remembered so the next frame starts right after DONE.
    assign req = (per_cnt == '0) || pending;

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick;
        bit_nxt   = bit_cnt;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = CONVST;
                    tick_nxt  = '0;
                    start     = 1'b1;
                end
            end
            CONVST: begin
                if (tick == CONVST_LAST) begin
                    state_nxt = WAIT;
                    tick_nxt  = '0;
                end else begin
                    tick_nxt = tick + 1'b1;
                end
            end
            WAIT: begin
                if (tick == CONV_LAST) begin
                    state_nxt = SHIFT;
                    tick_nxt  = '0;
                    bit_nxt   = '0;
                end else begin
                    tick_nxt = tick + 1'b1;
                end
            end
            SHIFT: begin
                if (tick == BIT_LAST) begin
                    tick_nxt = '0;
                    if (bit_cnt == 4'd11) begin
                        state_nxt = DONE;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    tick_nxt = tick + 1'b1;
                end
            end
            DONE: begin
                tick_nxt = '0;
                if (req) begin
                    state_nxt = CONVST;
                    start     = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pin outputs are registered from the next-state decode so SCK/CONVST never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tick       <= '0;
            bit_cnt    <= '0;
            per_cnt    <= '0;
            pending    <= 1'b0;
            shreg      <= '0;
            adc_convst <= 1'b0;
            adc_sck    <= 1'b0;
            adc_sdi    <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick       <= tick_nxt;
            bit_cnt    <= bit_nxt;
            per_cnt    <= (per_cnt == PER_LAST) ? '0 : per_cnt + 1'b1;
            pending    <= (pending || (per_cnt == '0)) && !start;
            adc_convst <= (state_nxt == CONVST);
            adc_sck    <= (state_nxt == SHIFT) && (tick_nxt >= SCK_RISE);
            adc_sdi    <= (state_nxt == SHIFT) && CFG[4'd11 - bit_nxt];
            if ((state_nxt == SHIFT) && (tick_nxt == SCK_RISE)) begin
                shreg <= {shreg[10:0], adc_sdo};
            end
        end
    end

`ifdef ADC_AVG_EN
    logic [3:0][11:0] hist;
    logic [13:0]      sum;
    logic [13:0]      sum_nxt;

    assign sum_nxt = sum + {2'b00, shreg} - {2'b00, hist[3]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist         <= '0;
            sum          <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                hist   <= {hist[2:0], shreg};
                sum    <= sum_nxt;
                sample <= sum_nxt[13:2];
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                sample <= shreg;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench: two samplers (defaults, and CHANNEL=5 / SAMPLE_PERIOD=50) each driven by a small ADC model.
module tb_adc_spi_sampler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        sdo0, convst0, sck0, sdi0, vld0;
    logic [11:0] smp0;
    logic        sdo1, convst1, sck1, sdi1, vld1;
    logic [11:0] smp1;

    adc_spi_sampler dut0 (
        .clk(clk), .reset(reset), .adc_sdo(sdo0), .adc_convst(convst0),
        .adc_sck(sck0), .adc_sdi(sdi0), .sample(smp0), .sample_valid(vld0)
    );

    adc_spi_sampler #(.SAMPLE_PERIOD(50), .CHANNEL(5)) dut1 (
        .clk(clk), .reset(reset), .adc_sdo(sdo1), .adc_convst(convst1),
        .adc_sck(sck1), .adc_sdi(sdi1), .sample(smp1), .sample_valid(vld1)
    );

    // Raw ADC words handed out one per CONVST pulse
    logic [11:0] words0 [5] = '{12'hA5C, 12'hFFF, 12'h000, 12'h123, 12'h3C5};
    logic [11:0] words1 [7] = '{12'h400, 12'h400, 12'h400, 12'h400, 12'h000, 12'h7FF, 12'h800};

`ifdef ADC_AVG_EN
    logic [11:0] exp0 [4] = '{12'h297, 12'h696, 12'h696, 12'h0F1};
    logic [11:0] exp1 [6] = '{12'h100, 12'h200, 12'h300, 12'h400, 12'h300, 12'h200};
`else
    logic [11:0] exp0 [4] = '{12'hA5C, 12'hFFF, 12'h000, 12'h3C5};
    logic [11:0] exp1 [6] = '{12'h400, 12'h400, 12'h400, 12'h400, 12'h000, 12'h800};
`endif

    int          wi0 = 0, wi1 = 0;
    int          bi0 = -1, bi1 = -1;
    logic [11:0] cur0 = '0, cur1 = '0;

    always @(posedge convst0) begin
        cur0 = words0[wi0 % 5];
        wi0++;
        bi0 = 11;
    end
    always @(posedge sck0) bi0--;
    assign sdo0 = (bi0 >= 0) ? cur0[bi0[3:0]] : 1'b0;

    always @(posedge convst1) begin
        cur1 = words1[wi1 % 7];
        wi1++;
        bi1 = 11;
    end
    always @(posedge sck1) bi1--;
    assign sdo1 = (bi1 >= 0) ? cur1[bi1[3:0]] : 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Per-DUT event log, cycle 0 = first clk edge after reset release
    int          cyc;
    int          conv_t [2][8];
    int          conv_n [2];
    int          conv_hi [2];
    int          vld_t [2][8];
    logic [11:0] vld_s [2][8];
    int          vld_n [2];
    int          sck_n [2];
    logic [11:0] sdi_w [2];
    int          dbl [2];
    logic        p_conv [2];
    logic        p_sck [2];
    logic        p_vld [2];

    task automatic clear_log();
        for (int d = 0; d < 2; d++) begin
            conv_n[d] = 0; conv_hi[d] = 0; vld_n[d] = 0;
            sck_n[d] = 0; sdi_w[d] = '0; dbl[d] = 0;
        end
    endtask

    task automatic mon(input int d, input logic cv, input logic sk, input logic si,
                       input logic vl, input logic [11:0] sm);
        if (cv && !p_conv[d]) begin
            if (conv_n[d] < 8) conv_t[d][conv_n[d]] = cyc;
            conv_n[d]++;
            conv_hi[d] = 0;
            sck_n[d] = 0;
            sdi_w[d] = '0;
        end
        if (cv) conv_hi[d]++;
        if (sk && !p_sck[d]) begin
            sck_n[d]++;
            sdi_w[d] = {sdi_w[d][10:0], si};
        end
        if (vl && p_vld[d]) dbl[d]++;
        if (vl) begin
            if (vld_n[d] < 8) begin
                vld_t[d][vld_n[d]] = cyc;
                vld_s[d][vld_n[d]] = sm;
            end
            vld_n[d]++;
        end
        p_conv[d] = cv;
        p_sck[d]  = sk;
        p_vld[d]  = vl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        mon(0, convst0, sck0, sdi0, vld0, smp0);
        mon(1, convst1, sck1, sdi1, vld1, smp1);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        cyc = -1;
        clear_log();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            p_conv[d] = 1'b0; p_sck[d] = 1'b0; p_vld[d] = 1'b0;
        end
        clear_log();
        cyc = -1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_convst", 32'(convst0), 0);
        check("rst_sck", 32'(sck0), 0);
        check("rst_sdi", 32'(sdi0), 0);
        check("rst_sample", 32'(smp0), 0);
        check("rst_valid", 32'(vld0), 0);

        // First frame after reset release
        release_reset();
        step();
        check("convst_cycle0", 32'(convst0), 1);
        run_to(130);
        check("conv_first_t", conv_t[0][0], 0);
        check("convst_width", conv_hi[0], 2);
        check("sck_rises", sck_n[0], 12);
        check("sdi_ch0", 32'(sdi_w[0]), 'h880);
        check("valid_count1", vld_n[0], 1);
        check("valid_t1", vld_t[0][0], 130);
        check("sample1", 32'(vld_s[0][0]), 32'(exp0[0]));
        check("sdi_ch5", 32'(sdi_w[1]), 'hE80);
        check("sck_rises_d1", sck_n[1], 12);
        check("valid_t1_d1", vld_t[1][0], 130);
        check("sample1_d1", 32'(vld_s[1][0]), 32'(exp1[0]));

        run_to(199);
        check("sample_hold", 32'(smp0), 32'(exp0[0]));
        check("valid_idle", 32'(vld0), 0);

        // Periodic scheduling, toggling data, back-to-back frames
        run_to(660);
        check("conv_t2", conv_t[0][1], 200);
        check("conv_t3", conv_t[0][2], 400);
        check("conv_t4", conv_t[0][3], 600);
        check("valid_count3", vld_n[0], 3);
        check("valid_t2", vld_t[0][1], 330);
        check("sample2", 32'(vld_s[0][1]), 32'(exp0[1]));
        check("sample3", 32'(vld_s[0][2]), 32'(exp0[2]));
        check("b2b_conv_t2", conv_t[1][1], 131);
        check("b2b_conv_t3", conv_t[1][2], 262);
        check("b2b_conv_t4", conv_t[1][3], 393);
        check("b2b_conv_t5", conv_t[1][4], 524);
        check("b2b_valid_count", vld_n[1], 5);
        check("b2b_valid_t5", vld_t[1][4], 654);
        for (int i = 1; i < 5; i++)
            check($sformatf("b2b_sample%0d", i + 1), 32'(vld_s[1][i]), 32'(exp1[i]));
        check("valid_doubled_d0", dbl[0], 0);
        check("valid_doubled_d1", dbl[1], 0);

        // Reset in the middle of the shift phase, with SCK high
        run_to(709);
        check("mid_sck_rises", sck_n[0], 7);
        check("mid_sck_high", 32'(sck0), 1);
        reset = 1'b1;
        #1;
        check("abort_convst", 32'(convst0), 0);
        check("abort_sck", 32'(sck0), 0);
        check("abort_sdi", 32'(sdi0), 0);
        check("abort_sample", 32'(smp0), 0);
        check("abort_valid", 32'(vld0), 0);
        check("abort_sample_d1", 32'(smp1), 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_sample_held", 32'(smp0), 0);

        release_reset();
        run_to(129);
        check("post_rst_no_partial", 32'(smp0), 0);
        run_to(135);
        check("post_rst_valid_count", vld_n[0], 1);
        check("post_rst_valid_t", vld_t[0][0], 130);
        check("post_rst_sample", 32'(vld_s[0][0]), 32'(exp0[3]));
        check("post_rst_sample_d1", 32'(vld_s[1][0]), 32'(exp1[5]));
        check("post_rst_doubled", dbl[0] + dbl[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
